// File: rtl/sync_block_pkg.sv
// Shared types and parameter defaults for the opto input conditioner.
// Holds the filter FSM state encoding used by the top and the bench.
package sync_block_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 16;
  localparam int HOLDOFF_LEN_DEF = 1000;
  localparam int INVERT_DEF      = 0;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } filt_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Resets every stage to 0.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r;

  // shift chain; last stage is the synchronised output
  always_ff @(posedge clock) begin
    if (reset) r <= '0;
    else       r <= {r[DEPTH-2:0], d};
  end

  assign q = r[DEPTH-1];

endmodule

// File: rtl/opto_input_conditioner.sv
// Opto-coupler input conditioner: sync, glitch filter, edge pulse,
// holdoff with sticky overrun, and an emitted-edge counter.
module opto_input_conditioner
  import sync_block_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int HOLDOFF_LEN = HOLDOFF_LEN_DEF,
  parameter int INVERT      = INVERT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        opto_in,
  input  logic        enable,
  input  logic        clear_overrun,
  output logic        fg_pulse,
  output logic        opto_level,
  output logic [31:0] edge_count,
  output logic        overrun,
  output logic [1:0]  filter_state
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam int HW = (HOLDOFF_LEN < 1) ? 1 : $clog2(HOLDOFF_LEN + 1);

  logic          sync_q;
  logic          s;
  filt_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          qual;
  logic [HW-1:0] hold;
  logic          emit;
  logic          supp;

  sync_ff #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (opto_in),
    .q    (sync_q)
  );

  assign s = sync_q ^ (INVERT != 0);

  // filter state and stability counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next-state: a level must hold FILTER_LEN cycles to be accepted
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    qual    = 1'b0;
    unique case (state)
      LOW: begin
        if (s) begin
          state_n = QUAL_HIGH;
          cnt_n   = CW'(1);
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          state_n = LOW;
          cnt_n   = '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
          state_n = HIGH;
          cnt_n   = '0;
          qual    = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_n = QUAL_LOW;
          cnt_n   = CW'(1);
        end
      end
      QUAL_LOW: begin
        if (s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign emit = qual & enable & (hold == '0);
  assign supp = qual & enable & (hold != '0);

  // pulse, counter, holdoff and sticky overrun
  always_ff @(posedge clock) begin
    if (reset) begin
      fg_pulse   <= 1'b0;
      opto_level <= 1'b0;
      edge_count <= '0;
      hold       <= '0;
      overrun    <= 1'b0;
    end else begin
      fg_pulse   <= emit;
      opto_level <= (state_n == HIGH) || (state_n == QUAL_LOW);
      if (emit) begin
        edge_count <= edge_count + 32'd1;
        hold       <= HW'(HOLDOFF_LEN);
      end else if (!supp && hold != '0) begin
        hold <= hold - HW'(1);
      end
      if (supp)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  assign filter_state = state;

endmodule

// File: tb/tb_opto_input_conditioner.sv
// Directed self-checking bench for opto_input_conditioner.
// Default parameters: 2 sync stages, filter 16, holdoff 1000.
module tb_opto_input_conditioner;

  logic        clock;
  logic        reset;
  logic        opto_in;
  logic        enable;
  logic        clear_overrun;
  logic        fg_pulse;
  logic        opto_level;
  logic [31:0] edge_count;
  logic        overrun;
  logic [1:0]  filter_state;

  int n_checks = 0;
  int n_fail   = 0;
  int t;
  int ptime[$];
  bit lvl_seen;

  opto_input_conditioner dut (
    .clock        (clock),
    .reset        (reset),
    .opto_in      (opto_in),
    .enable       (enable),
    .clear_overrun(clear_overrun),
    .fg_pulse     (fg_pulse),
    .opto_level   (opto_level),
    .edge_count   (edge_count),
    .overrun      (overrun),
    .filter_state (filter_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic seg(input logic lvl, input int n);
    opto_in = lvl;
    repeat (n) begin
      @(posedge clock);
      #1;
      t++;
      if (fg_pulse === 1'b1) ptime.push_back(t);
      if (opto_level === 1'b1) lvl_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    opto_in = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    t = 0;
    ptime.delete();
    lvl_seen = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    do_reset();
    n_checks++;
    if (fg_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse got %b want 0", fg_pulse);
    end
    n_checks++;
    if (opto_level !== 1'b0) begin
      n_fail++; $display("FAIL reset_level got %b want 0", opto_level);
    end
    n_checks++;
    if (edge_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", edge_count);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun got %b want 0", overrun);
    end
    n_checks++;
    if (filter_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got %0d want 0", filter_state);
    end
  endtask

  task automatic test_clean_rise();
    int p0;
    do_reset();
    seg(1'b1, 100);
    p0 = (ptime.size() > 0) ? ptime[0] : -1;
    n_checks++;
    if (ptime.size() != 1) begin
      n_fail++; $display("FAIL rise_npulse got %0d want 1", ptime.size());
    end
    n_checks++;
    if (p0 != 18) begin
      n_fail++; $display("FAIL rise_latency got %0d want 18", p0);
    end
    n_checks++;
    if (opto_level !== 1'b1) begin
      n_fail++; $display("FAIL rise_level got %b want 1", opto_level);
    end
    n_checks++;
    if (edge_count !== 32'd1) begin
      n_fail++; $display("FAIL rise_count got %0d want 1", edge_count);
    end
    seg(1'b0, 40);
    n_checks++;
    if (opto_level !== 1'b0) begin
      n_fail++; $display("FAIL fall_level got %b want 0", opto_level);
    end
    n_checks++;
    if (filter_state !== 2'd0) begin
      n_fail++; $display("FAIL fall_state got %0d want 0", filter_state);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    seg(1'b1, 10);
    seg(1'b0, 40);
    n_checks++;
    if (ptime.size() != 0) begin
      n_fail++; $display("FAIL glitch_npulse got %0d want 0", ptime.size());
    end
    n_checks++;
    if (lvl_seen !== 1'b0) begin
      n_fail++; $display("FAIL glitch_level got %b want 0", lvl_seen);
    end
    n_checks++;
    if (filter_state !== 2'd0) begin
      n_fail++; $display("FAIL glitch_state got %0d want 0", filter_state);
    end
    n_checks++;
    if (edge_count !== 32'd0) begin
      n_fail++; $display("FAIL glitch_count got %0d want 0", edge_count);
    end
  endtask

  task automatic test_holdoff();
    int p0, p1;
    do_reset();
    seg(1'b1, 100);
    seg(1'b0, 400);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL hold_ovr_pre got %b want 0", overrun);
    end
    seg(1'b1, 100);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL hold_ovr_post got %b want 1", overrun);
    end
    seg(1'b0, 1000);
    seg(1'b1, 100);
    seg(1'b0, 50);
    p0 = (ptime.size() > 0) ? ptime[0] : -1;
    p1 = (ptime.size() > 1) ? ptime[1] : -1;
    n_checks++;
    if (ptime.size() != 2) begin
      n_fail++; $display("FAIL hold_npulse got %0d want 2", ptime.size());
    end
    n_checks++;
    if (p0 != 18) begin
      n_fail++; $display("FAIL hold_p0 got %0d want 18", p0);
    end
    n_checks++;
    if (p1 != 1618) begin
      n_fail++; $display("FAIL hold_p1 got %0d want 1618", p1);
    end
    n_checks++;
    if (edge_count !== 32'd2) begin
      n_fail++; $display("FAIL hold_count got %0d want 2", edge_count);
    end
  endtask

  task automatic test_enable();
    int p0;
    do_reset();
    enable = 1'b0;
    seg(1'b1, 40);
    enable = 1'b1;
    seg(1'b1, 40);
    n_checks++;
    if (ptime.size() != 0) begin
      n_fail++; $display("FAIL en_npulse got %0d want 0", ptime.size());
    end
    n_checks++;
    if (opto_level !== 1'b1) begin
      n_fail++; $display("FAIL en_level got %b want 1", opto_level);
    end
    n_checks++;
    if (edge_count !== 32'd0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL en_side got cnt=%0d ovr=%b want 0/0", edge_count, overrun);
    end
    seg(1'b0, 40);
    seg(1'b1, 40);
    p0 = (ptime.size() > 0) ? ptime[0] : -1;
    n_checks++;
    if (ptime.size() != 1 || p0 != 138) begin
      n_fail++;
      $display("FAIL en_next got n=%0d at %0d want 1 at 138", ptime.size(), p0);
    end
  endtask

  task automatic test_reset_midqual();
    int p0;
    do_reset();
    seg(1'b1, 10);
    n_checks++;
    if (filter_state !== 2'd1) begin
      n_fail++; $display("FAIL mq_state got %0d want 1", filter_state);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (filter_state !== 2'd0) begin
      n_fail++; $display("FAIL mq_rst_state got %0d want 0", filter_state);
    end
    reset = 1'b0;
    t = 0;
    ptime.delete();
    seg(1'b1, 40);
    p0 = (ptime.size() > 0) ? ptime[0] : -1;
    n_checks++;
    if (ptime.size() != 1 || p0 != 18) begin
      n_fail++;
      $display("FAIL mq_pulse got n=%0d at %0d want 1 at 18", ptime.size(), p0);
    end
    n_checks++;
    if (edge_count !== 32'd1) begin
      n_fail++; $display("FAIL mq_count got %0d want 1", edge_count);
    end
  endtask

  task automatic test_clear_same_cycle();
    seg(1'b0, 40);
    seg(1'b1, 17);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_pre got %b want 0", overrun);
    end
    clear_overrun = 1'b1;
    seg(1'b1, 1);
    clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b1 || fg_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_same got ovr=%b pulse=%b want 1/0", overrun, fg_pulse);
    end
    clear_overrun = 1'b1;
    seg(1'b1, 1);
    clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone got %b want 0", overrun);
    end
    n_checks++;
    if (edge_count !== 32'd1) begin
      n_fail++; $display("FAIL clr_count got %0d want 1", edge_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    opto_in = 1'b0;
    enable = 1'b1;
    clear_overrun = 1'b0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_holdoff();
    test_enable();
    test_reset_midqual();
    test_clear_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opto_input_conditioner.md
OPTO_INPUT_CONDITIONER -- requirements
Module: opto_input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on opto_in; legal range 2..4.
REQ-002 Parameter FILTER_LEN, default 16: consecutive stable cycles required to accept a level change; legal minimum 2.
REQ-003 Parameter HOLDOFF_LEN, default 1000: cycles after an emitted pulse during which further rising edges are suppressed; 0 disables holdoff.
REQ-004 Parameter INVERT, default 0: 1 treats a low opto_in as active.
REQ-005 clock  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 opto_in  in  1  asynchronous frame-grabber opto-coupler line.
REQ-008 enable  in  1  1 = qualified rising edges may emit fg_pulse.
REQ-009 clear_overrun  in  1  single-cycle clear of overrun.
REQ-010 fg_pulse  out  1  one-cycle pulse per accepted rising edge; feeds the trigger FSM's fg_signal.
REQ-011 opto_level  out  1  filtered input level.
REQ-012 edge_count  out  32  count of emitted fg_pulse.
REQ-013 overrun  out  1  sticky flag: a qualified edge was suppressed by holdoff.
REQ-014 filter_state  out  2  current FSM state encoding, for debug.

Function
REQ-015 opto_in SHALL pass through SYNC_STAGES flops; the result XOR INVERT is s.
REQ-016 FSM states SHALL be LOW=0, QUAL_HIGH=1, HIGH=2, QUAL_LOW=3, with filter counter cnt.
REQ-017 In LOW: s=1 -> QUAL_HIGH with cnt<=1; otherwise stay in LOW.
REQ-018 In QUAL_HIGH: s=0 -> LOW, cnt<=0; else cnt=FILTER_LEN-1 -> HIGH, cnt<=0, qualified rising edge; else cnt++.
REQ-019 In HIGH: s=0 -> QUAL_LOW with cnt<=1; otherwise stay in HIGH.
REQ-020 In QUAL_LOW: s=1 -> HIGH, cnt<=0; else cnt=FILTER_LEN-1 -> LOW, cnt<=0; else cnt++.
REQ-021 opto_level SHALL be 1 in HIGH and QUAL_LOW, and 0 otherwise; it is registered.
REQ-022 Latency from a stable opto_in rising edge to fg_pulse SHALL be SYNC_STAGES+FILTER_LEN clock edges (18 with defaults).
REQ-023 A qualified rising edge SHALL emit fg_pulse (registered, exactly one cycle) only when enable=1 and the holdoff counter is 0.
REQ-024 On emit: edge_count++ (wrap 0xFFFFFFFF->0) and holdoff counter<=HOLDOFF_LEN; the holdoff counter decrements to 0 each cycle.
REQ-025 A qualified edge with enable=1 and holdoff counter nonzero SHALL emit no pulse, set overrun, and leave the holdoff counter unchanged.
REQ-026 A qualified edge with enable=0 SHALL be discarded with no pulse, no count change and no overrun change; the FSM keeps tracking, so enabling while the line is high emits nothing.
REQ-027 clear_overrun SHALL clear overrun, except that a set in the same cycle wins.
REQ-028 Glitches shorter than FILTER_LEN cycles SHALL produce no output change.

Reset
REQ-029 reset SHALL force: synchroniser flops 0 (inactive after INVERT), state LOW, cnt 0, holdoff counter 0, fg_pulse 0, opto_level 0, edge_count 0, overrun 0.
REQ-030 Reset asserted mid-qualification SHALL abandon it.
REQ-031 An input held active through reset release SHALL be requalified in full and emit one pulse SYNC_STAGES+FILTER_LEN edges after release (if enable=1).

Structure
REQ-032 The state enum typedef and parameter defaults SHALL live in shared package sync_block_pkg.
REQ-033 The synchroniser SHALL be sub-module sync_ff (parameterised depth, reset value 0).

Verification (defaults unless noted)
REQ-034 opto_in high for 100 cycles -> one fg_pulse 18 edges after the rise; opto_level=1; edge_count=1.
REQ-035 10-cycle high glitch -> no fg_pulse; opto_level stays 0; filter_state returns to 0.
REQ-036 Clean edges at t=0, 500 and 1600 -> pulses at edges 1 and 3 only; overrun=1 after edge 2; edge_count=2.
REQ-037 enable=0 during the rise, enable=1 while the line is held high -> no pulse; the next clean edge pulses.
REQ-038 Reset in QUAL_HIGH at cnt=8 with input held high -> pulse 18 edges after release; edge_count=1.
REQ-039 clear_overrun in the same cycle as a suppressed edge -> overrun=1.
